// File: rtl/sm3_expnd_core.sv
// rtl/sm3_expnd_core.sv - SM3 message expansion, double-buffered block load, optional output slice (SM3_EXPND_OTPT_REG_EN)
module sm3_expnd_core #(
    parameter int INPT_DW = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INPT_DW-1:0] pad_inpt_d_i,
    input  logic               pad_inpt_vld_i,
    input  logic               pad_inpt_lst_i,
    output logic               pad_inpt_rdy_o,
    output logic [31:0]        expnd_otpt_wj_o,
    output logic [31:0]        expnd_otpt_wjj_o,
    output logic [5:0]         expnd_otpt_idx_o,
    output logic               expnd_otpt_vld_o,
    input  logic               expnd_otpt_rdy_i,
    output logic               expnd_otpt_msg_lst_o,
    output logic               err_ovf_o
);
    localparam int WN = INPT_DW / 32;

    typedef enum logic {S_IDLE, S_EXPND} state_t;
    state_t state, state_nxt;

    logic [31:0] ld_buf [16];
    logic [4:0]  ld_cnt;
    logic        ld_full;
    logic        ld_lst;
    logic [31:0] win [16];
    logic [5:0]  win_idx;
    logic        win_lst;
    logic        win_vld;
    logic        win_adv;
    logic        win_last_adv;
    logic        eng_busy;
    logic        xfer;
    logic [31:0] win_new;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl(x, 15) ^ rotl(x, 23);
    endfunction

    assign win_vld      = (state == S_EXPND);
    assign win_last_adv = win_adv && (win_idx == 6'd63);
    // The engine counts as free during its final advance so the next block can slide in without a bubble
    assign eng_busy     = win_vld && !win_last_adv;
    assign ld_full      = ld_cnt[4];
    assign xfer         = ld_full && !eng_busy;
    // Drop ready one beat early while busy: the padding core always has one beat in flight
    assign pad_inpt_rdy_o = !ld_full && ((ld_cnt < 5'(16 - WN)) || !eng_busy);
    assign win_new = p1(win[0] ^ win[7] ^ rotl(win[13], 15)) ^ rotl(win[3], 7) ^ win[10];

`ifdef SM3_EXPND_OTPT_REG_EN
    logic        sl_vld;
    logic [31:0] sl_wj;
    logic [31:0] sl_wjj;
    logic [5:0]  sl_idx;
    logic        sl_lst;

    assign win_adv = win_vld && (!sl_vld || expnd_otpt_rdy_i);

    // Output slice: refilled from the window whenever it is empty or being drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sl_vld <= 1'b0;
            sl_wj  <= '0;
            sl_wjj <= '0;
            sl_idx <= '0;
            sl_lst <= 1'b0;
        end else if (win_adv) begin
            sl_vld <= 1'b1;
            sl_wj  <= win[0];
            sl_wjj <= win[0] ^ win[4];
            sl_idx <= win_idx;
            sl_lst <= win_lst;
        end else if (expnd_otpt_rdy_i) begin
            sl_vld <= 1'b0;
        end
    end

    assign expnd_otpt_vld_o     = sl_vld;
    assign expnd_otpt_wj_o      = sl_wj;
    assign expnd_otpt_wjj_o     = sl_wjj;
    assign expnd_otpt_idx_o     = sl_idx;
    assign expnd_otpt_msg_lst_o = sl_lst;
`else
    assign win_adv = win_vld && expnd_otpt_rdy_i;

    assign expnd_otpt_vld_o     = win_vld;
    assign expnd_otpt_wj_o      = win[0];
    assign expnd_otpt_wjj_o     = win[0] ^ win[4];
    assign expnd_otpt_idx_o     = win_idx;
    assign expnd_otpt_msg_lst_o = win_lst;
`endif

    // Load buffer: accept WN words per valid beat until full; a beat arriving while full is dropped and flagged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt    <= '0;
            ld_lst    <= 1'b0;
            err_ovf_o <= 1'b0;
            for (int i = 0; i < 16; i++) ld_buf[i] <= '0;
        end else begin
            if (pad_inpt_vld_i && ld_full) err_ovf_o <= 1'b1;
            if (xfer) begin
                ld_cnt <= '0;
            end else if (pad_inpt_vld_i && !ld_full) begin
                for (int k = 0; k < WN; k++)
                    ld_buf[ld_cnt[3:0] + 4'(k)] <= pad_inpt_d_i[INPT_DW-1-32*k -: 32];
                ld_cnt <= ld_cnt + 5'(WN);
                ld_lst <= pad_inpt_lst_i;
            end
        end
    end

    // Expansion window: load a whole block on transfer, otherwise shift in W_(j+16) on each advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_idx <= '0;
            win_lst <= 1'b0;
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else if (xfer) begin
            win_idx <= '0;
            win_lst <= ld_lst;
            for (int i = 0; i < 16; i++) win[i] <= ld_buf[i];
        end else if (win_adv) begin
            win_idx <= win_idx + 6'd1;
            for (int i = 0; i < 15; i++) win[i] <= win[i + 1];
            win[15] <= win_new;
        end
    end

    // Engine state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Engine next state: start on transfer, finish after round 63 unless another block follows directly
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (xfer) state_nxt = S_EXPND;
            S_EXPND: if (win_last_adv && !xfer) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule
